pe_8x4_loader: RTL and testbench
================================

Name: pe_8x4_loader

Overview:
- Upstream feeder for the 8-input, 4-output 16-bit processing element.
- Accepts a serial 16-bit word stream on a valid/ready handshake and packs it into the PE's 128-bit DATA bus and 512-bit WEIGHT bus.
- Drives the PE clock enable for the PE's pipeline latency, then captures the PE's 64-bit output and presents it downstream on a valid/ready handshake.
- One loader per PE; frames are handled strictly one at a time.

Parameters:
- WORD_LEN, 16, word width in bits.
- NEU_IN, 8, PE inputs per frame.
- NEU_OUT, 4, PE outputs per frame.
- PE_LAT, 3, clocks from DATA/WEIGHT stable to PE Q valid with ce held high; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_data  in  WORD_LEN  serial word: signed Q0.15 neuron state or synapse weight.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle.
- pe_data  out  WORD_LEN*NEU_IN  to PE DATA.
- pe_weight  out  WORD_LEN*NEU_IN*NEU_OUT  to PE WEIGHT.
- pe_ce  out  1  to PE ce.
- pe_q  in  WORD_LEN*NEU_OUT  from PE Q.
- q_out  out  WORD_LEN*NEU_OUT  captured PE result, Q0.15 per neuron.
- q_valid  out  1  q_out valid.
- q_ready  in  1  downstream accepts q_out.
- busy  out  1  high in any state other than S_LOAD_D with cnt=0.

Behaviour:
- Transfer rule: a word transfers on a rising edge where in_valid and in_ready are both high. q_out transfers where q_valid and q_ready are both high.
- State S_LOAD_D:
  - in_ready=1.
  - Transferred word k (0..NEU_IN-1) is written to pe_data[16k+15:16k].
  - Counter cnt increments per transfer; on k=NEU_IN-1, go to S_LOAD_W with cnt=0.
- State S_LOAD_W:
  - in_ready=1.
  - Word j (0..NEU_IN*NEU_OUT-1) is written to pe_weight[16j+15:16j], where j = out*NEU_IN + in.
  - On j=NEU_IN*NEU_OUT-1, go to S_FIRE with cnt=0.
- State S_FIRE:
  - in_ready=0, pe_ce=1 (registered output, so ce is high on exactly PE_LAT consecutive clocks).
  - pe_data and pe_weight are held constant.
  - After PE_LAT cycles, capture q_out<=pe_q, set q_valid=1, go to S_OUT.
- State S_OUT:
  - in_ready=0, pe_ce=0, q_valid=1.
  - q_out is held stable until the handshake completes.
  - On q_ready, clear q_valid and go to S_LOAD_D with cnt=0.
- Stalls: in_valid low mid-load causes no advance and no register change. q_ready low holds S_OUT indefinitely.
- No combinational path from in_valid to in_ready or from q_ready to q_valid. in_ready is decoded from state only.
- Back-to-back frames: the first word of the next frame can transfer on the cycle after the q_out handshake.
- pe_data and pe_weight keep their old contents until overwritten word by word. The PE output is ignored outside S_FIRE, so the mixed contents during loading are harmless.
- Reset, including mid-frame:
  - Next state S_LOAD_D, cnt=0.
  - pe_data=0, pe_weight=0, pe_ce=0, q_out=0, q_valid=0; in_ready=1 on the first cycle after reset.
  - Any partial frame is discarded.
- Minimum frame latency: 8 + 32 + PE_LAT + 1 clocks from the first word to q_valid, with in_valid held high.

Optional Feature:
- Macro: PE_LOADER_WEIGHT_REUSE_EN.
- Defined:
  - Adds input port reuse_w (1 bit).
  - reuse_w is sampled on the last S_LOAD_D transfer. If high, S_LOAD_W is skipped, the FSM goes directly to S_FIRE, and pe_weight keeps the previous frame's weights.
  - The first frame after reset must have reuse_w=0; otherwise the weights are all zero.
- Undefined: the port is absent and every frame loads NEU_IN*NEU_OUT weights.

Decomposition:
- Package pe_loader_pkg holds:
  - state encoding S_LOAD_D=2'd0, S_LOAD_W=2'd1, S_FIRE=2'd2, S_OUT=2'd3;
  - localparam CNT_W = clog2(NEU_IN*NEU_OUT), wide enough for PE_LAT;
  - frame word-count constants.
- One sub-module, pe_word_packer: a write-indexed register file (index, word, write enable) instantiated twice, once for pe_data and once for pe_weight.
- The FSM and output capture stay at the top level.

Test Plan:
- Reset, then load data 0x0001..0x0008 and weights 0x0100+j, all with in_valid held high:
  - pe_data[15:0]=0x0001 and pe_data[127:112]=0x0008;
  - pe_weight[511:496]=0x011F;
  - pe_ce high for exactly 3 clocks;
  - q_valid rises on clock 44 after the first word.
- Model the PE as Q = per-output sum with a 3-clock delay, feeding 0x1234_5678_9ABC_DEF0 → q_out equals that value, held stable while q_ready=0 for 10 cycles, then q_valid clears one cycle after q_ready=1.
- Random in_valid gaps (50% duty) → same packed buses as the gap-free run; in_ready=0 throughout S_FIRE and S_OUT.
- Assert rst_n=0 after 20 words → next cycle all outputs are zero and in_ready=1; a fresh full frame then completes correctly.
- Assert q_ready in the same cycle q_valid rises, then start the next frame immediately → no lost or duplicated word, and the second q_out matches the model.
- With PE_LOADER_WEIGHT_REUSE_EN defined: frame 2 with reuse_w=1 → only 8 words accepted, pe_weight unchanged, q_valid 8+3+1 clocks after the first word.

Source files
------------

// File: rtl/pe_loader_pkg.sv
// Shared definitions for the PE loader: FSM state encoding, frame sizes and counter width.
package pe_loader_pkg;

    typedef enum logic [1:0] {
        S_LOAD_D = 2'd0,
        S_LOAD_W = 2'd1,
        S_FIRE   = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    localparam int unsigned WORD_LEN_DEF = 16;
    localparam int unsigned NEU_IN_DEF   = 8;
    localparam int unsigned NEU_OUT_DEF  = 4;
    localparam int unsigned PE_LAT_DEF   = 3;

    localparam int unsigned DATA_WORDS   = NEU_IN_DEF;
    localparam int unsigned WEIGHT_WORDS = NEU_IN_DEF * NEU_OUT_DEF;
    localparam int unsigned FRAME_WORDS  = DATA_WORDS + WEIGHT_WORDS;

    // One counter serves as word index while loading and as the fire-cycle count,
    // so it has to cover both the weight count and PE_LAT.
    function automatic int unsigned cnt_width(input int unsigned words, input int unsigned lat);
        int unsigned a;
        int unsigned b;
        a = (words > 1) ? $clog2(words) : 1;
        b = $clog2(lat + 1);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CNT_W = cnt_width(WEIGHT_WORDS, PE_LAT_DEF);

endpackage

// File: rtl/pe_word_packer.sv
// Write-indexed word register file exposed as one flat bus; word i occupies bits [W*i +: W].
module pe_word_packer #(
    parameter int unsigned WORD_LEN = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned IDX_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IDX_W-1:0]          idx,
    input  logic [WORD_LEN-1:0]       word,
    input  logic                      we,
    output logic [WORD_LEN*DEPTH-1:0] bus
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (we && (idx == IDX_W'(i))) begin
                    bus[i*WORD_LEN +: WORD_LEN] <= word;
                end
            end
        end
    end

endmodule

// File: rtl/pe_8x4_loader.sv
// Serial-to-parallel feeder for the 8-in/4-out PE: loads DATA and WEIGHT, pulses ce, captures Q.
// Optional macro PE_LOADER_WEIGHT_REUSE_EN adds reuse_w to skip the weight load phase.
module pe_8x4_loader
    import pe_loader_pkg::*;
#(
    parameter int unsigned WORD_LEN = WORD_LEN_DEF,
    parameter int unsigned NEU_IN   = NEU_IN_DEF,
    parameter int unsigned NEU_OUT  = NEU_OUT_DEF,
    parameter int unsigned PE_LAT   = PE_LAT_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [WORD_LEN-1:0]                 in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
`ifdef PE_LOADER_WEIGHT_REUSE_EN
    input  logic                                reuse_w,
`endif
    output logic [WORD_LEN*NEU_IN-1:0]          pe_data,
    output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]  pe_weight,
    output logic                                pe_ce,
    input  logic [WORD_LEN*NEU_OUT-1:0]         pe_q,
    output logic [WORD_LEN*NEU_OUT-1:0]         q_out,
    output logic                                q_valid,
    input  logic                                q_ready,
    output logic                                busy
);

    localparam int unsigned W_WORDS = NEU_IN * NEU_OUT;
    localparam int unsigned CW      = cnt_width(W_WORDS, PE_LAT);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic            ce_nx;
    logic            d_we;
    logic            w_we;
    logic            capture;
    logic            xfer;

    assign in_ready = (state == S_LOAD_D) || (state == S_LOAD_W);
    assign q_valid  = (state == S_OUT);
    assign busy     = !((state == S_LOAD_D) && (cnt == '0));
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_LOAD_D;
            cnt   <= '0;
            pe_ce <= 1'b0;
            q_out <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pe_ce <= ce_nx;
            if (capture) begin
                q_out <= pe_q;
            end
        end
    end

    // ce is raised on the edge that enters S_FIRE and dropped PE_LAT clocks later;
    // Q is sampled one clock after that, once the PE pipeline has settled.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ce_nx    = pe_ce;
        d_we     = 1'b0;
        w_we     = 1'b0;
        capture  = 1'b0;
        case (state)
            S_LOAD_D: begin
                if (xfer) begin
                    d_we = 1'b1;
                    if (cnt == CW'(NEU_IN - 1)) begin
                        cnt_nx = '0;
`ifdef PE_LOADER_WEIGHT_REUSE_EN
                        if (reuse_w) begin
                            state_nx = S_FIRE;
                            ce_nx    = 1'b1;
                        end else begin
                            state_nx = S_LOAD_W;
                        end
`else
                        state_nx = S_LOAD_W;
`endif
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            S_LOAD_W: begin
                if (xfer) begin
                    w_we = 1'b1;
                    if (cnt == CW'(W_WORDS - 1)) begin
                        cnt_nx   = '0;
                        state_nx = S_FIRE;
                        ce_nx    = 1'b1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            S_FIRE: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(PE_LAT - 1)) begin
                    ce_nx = 1'b0;
                end
                if (cnt == CW'(PE_LAT)) begin
                    capture  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_OUT;
                end
            end
            S_OUT: begin
                if (q_ready) begin
                    state_nx = S_LOAD_D;
                    cnt_nx   = '0;
                end
            end
        endcase
    end

    pe_word_packer #(
        .WORD_LEN (WORD_LEN),
        .DEPTH    (NEU_IN),
        .IDX_W    (CW)
    ) u_data_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (cnt),
        .word  (in_data),
        .we    (d_we),
        .bus   (pe_data)
    );

    pe_word_packer #(
        .WORD_LEN (WORD_LEN),
        .DEPTH    (W_WORDS),
        .IDX_W    (CW)
    ) u_weight_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (cnt),
        .word  (in_data),
        .we    (w_we),
        .bus   (pe_weight)
    );

endmodule

// File: tb/tb_pe_8x4_loader.sv
// Scoreboard bench for pe_8x4_loader with a 3-deep ce-gated PE model; covers PE_LOADER_WEIGHT_REUSE_EN when defined.
module tb_pe_8x4_loader;

    logic          clk;
    logic          rst_n;
    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  pe_data;
    logic [511:0]  pe_weight;
    logic          pe_ce;
    logic [63:0]   pe_q;
    logic [63:0]   q_out;
    logic          q_valid;
    logic          q_ready;
    logic          busy;
`ifdef PE_LOADER_WEIGHT_REUSE_EN
    logic          reuse_w;
`endif

    int            n_vec;
    int            n_err;
    int unsigned   cyc;
    int unsigned   t_first;
    int unsigned   t_hs;
    int unsigned   t_rise;
    int unsigned   ce_run;
    logic          hs_prev;

    logic [15:0]   stim [40];
    logic [127:0]  cur_d;
    logic [511:0]  cur_w;
    logic [63:0]   exp_q [$];

    logic          pe_force;
    logic [63:0]   force_val;
    logic [63:0]   s1, s2, s3;

    pe_8x4_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef PE_LOADER_WEIGHT_REUSE_EN
        .reuse_w   (reuse_w),
`endif
        .pe_data   (pe_data),
        .pe_weight (pe_weight),
        .pe_ce     (pe_ce),
        .pe_q      (pe_q),
        .q_out     (q_out),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pe_fn(input logic [127:0] d, input logic [511:0] w);
        logic [63:0] q;
        logic [31:0] acc;
        q = '0;
        for (int o = 0; o < 4; o++) begin
            acc = '0;
            for (int i = 0; i < 8; i++)
                acc = acc + 32'(d[16*i +: 16]) * 32'(w[16*(o*8+i) +: 16]);
            q[16*o +: 16] = acc[15:0];
        end
        return q;
    endfunction

    always @(posedge clk) begin
        if (pe_ce) begin
            s1 <= pe_force ? force_val : pe_fn(pe_data, pe_weight);
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign pe_q = s3;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pack_stim();
        for (int i = 0; i < 8; i++)  cur_d[16*i +: 16] = stim[i];
        for (int j = 0; j < 32; j++) cur_w[16*j +: 16] = stim[8+j];
    endtask

    task automatic prep_pattern();
        for (int i = 0; i < 8; i++)  stim[i]   = 16'(i + 1);
        for (int j = 0; j < 32; j++) stim[8+j] = 16'(16'h0100 + j);
        pack_stim();
    endtask

    task automatic prep_random();
        for (int i = 0; i < 40; i++) stim[i] = 16'($urandom);
        pack_stim();
    endtask

    task automatic send(input int unsigned n, input bit gaps);
        int unsigned k;
        int unsigned guard;
        k = 0;
        guard = 0;
        while (k < n) begin
            @(negedge clk);
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = stim[k];
            if (in_valid && in_ready) begin
                if (k == 0) t_first = cyc + 1;
                k++;
            end
            guard++;
            if (guard > 2000) begin
                chk("send_timeout", 0, 1);
                k = n;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (q_valid) begin
                t_rise = cyc;
                return;
            end
        end
        chk("q_valid_timeout", 0, 1);
    endtask

    // Output-side monitor, sampled 1 time unit after the falling edge.
    initial begin
        ce_run  = 0;
        hs_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (hs_prev) chk("ready_after_hs", in_ready, 1);
                if (pe_ce || q_valid) chk("in_ready_low", in_ready, 0);
                if (pe_ce) ce_run++;
                else if (ce_run != 0) begin
                    chk("ce_len", ce_run, 3);
                    ce_run = 0;
                end
                if (q_valid && q_ready) begin
                    t_hs = cyc + 1;
                    if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
                    else chk("q_out", q_out, exp_q.pop_front());
                end
                hs_prev = q_valid && q_ready;
            end else begin
                hs_prev = 1'b0;
                ce_run  = 0;
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pe_data"}, pe_data, 0);
        chk({tag, "_pe_weight"}, pe_weight, 0);
        chk({tag, "_pe_ce"}, pe_ce, 0);
        chk({tag, "_q_out"}, q_out, 0);
        chk({tag, "_q_valid"}, q_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        t_first = 0;
        t_hs = 0;
        t_rise = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        q_ready = 1'b0;
        pe_force = 1'b0;
        force_val = 64'h1234_5678_9ABC_DEF0;
        s1 = '0; s2 = '0; s3 = '0;
`ifdef PE_LOADER_WEIGHT_REUSE_EN
        reuse_w = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        rst_n = 1'b1;

        // Frame 1: fixed pattern, no gaps, forced PE result, downstream stalls 10 cycles.
        prep_pattern();
        pe_force = 1'b1;
        exp_q.push_back(force_val);
        send(40, 1'b0);
        chk("d_word0", pe_data[15:0], 16'h0001);
        chk("d_word7", pe_data[127:112], 16'h0008);
        chk("w_word31", pe_weight[511:496], 16'h011F);
        wait_valid();
        chk("latency_full", t_rise - t_first + 1, 44);
        for (int i = 0; i < 10; i++) begin
            chk("q_hold", q_out, 64'h1234_5678_9ABC_DEF0);
            chk("qv_hold", q_valid, 1);
            @(negedge clk);
        end
        q_ready = 1'b1;
        @(negedge clk);
        chk("qv_clear", q_valid, 0);
        pe_force = 1'b0;

        // Frame 2: same words with random valid gaps.
        exp_q.push_back(pe_fn(cur_d, cur_w));
        send(40, 1'b1);
        chk("gap_pe_data", pe_data, cur_d);
        chk("gap_pe_weight", pe_weight, cur_w);
        wait_valid();
        repeat (2) @(negedge clk);

        // Back-to-back frames with q_ready already high.
        prep_random();
        exp_q.push_back(pe_fn(cur_d, cur_w));
        send(40, 1'b0);
        prep_random();
        exp_q.push_back(pe_fn(cur_d, cur_w));
        send(40, 1'b0);
        chk("b2b_gap", t_first - t_hs, 1);
        chk("b2b_pe_data", pe_data, cur_d);
        chk("b2b_pe_weight", pe_weight, cur_w);
        wait_valid();
        repeat (2) @(negedge clk);

        // Reset mid-frame after 20 words, then a fresh frame.
        prep_random();
        send(20, 1'b0);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state("midrst");
        rst_n = 1'b1;
        prep_random();
        exp_q.push_back(pe_fn(cur_d, cur_w));
        send(40, 1'b1);
        chk("post_rst_weight", pe_weight, cur_w);
        wait_valid();
        repeat (2) @(negedge clk);

`ifdef PE_LOADER_WEIGHT_REUSE_EN
        // Reuse frame: 8 data words only, weights kept from the previous frame.
        for (int i = 0; i < 8; i++) stim[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) cur_d[16*i +: 16] = stim[i];
        exp_q.push_back(pe_fn(cur_d, cur_w));
        reuse_w = 1'b1;
        send(8, 1'b0);
        reuse_w = 1'b0;
        chk("reuse_in_ready", in_ready, 0);
        chk("reuse_weight", pe_weight, cur_w);
        chk("reuse_data", pe_data, cur_d);
        wait_valid();
        chk("latency_reuse", t_rise - t_first + 1, 12);
        repeat (2) @(negedge clk);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
